// File: rtl/pipe_addsub.sv
// Carry-pipelined adder/subtractor: one CHUNK-bit slice is added per stage.
// Operand chunks are skewed forward and result chunks ride along, so all of s lines up.
module pipe_addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

module pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CK     = (CHUNK >= 1) ? CHUNK : 1;
  localparam int STAGES = WIDTH / CK;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CK) != 0) begin : g_bad_cfg
    $error("pipe_addsub: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  logic              adv, acc;
  logic [STAGES:1]   vld_pipe;
  logic [WIDTH-1:0]  bx;

  // A stalled result freezes the whole pipe, so every register shares one enable.
  assign adv       = ~(out_valid & ~out_ready);
  assign in_ready  = adv;
  assign acc       = in_valid & in_ready;
  assign bx        = sub ? ~b : b;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= (vld_pipe << 1) | STAGES'(acc);

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [CK-1:0]        ca, cb, sum;
    logic                 ci, co, co_q;
    logic [(k+1)*CK-1:0]  res_d, res_q;

    if (k == 0) begin : g_src
      assign ca    = a[CK-1:0];
      assign cb    = bx[CK-1:0];
      assign ci    = cin ^ sub;
      assign res_d = sum;
    end else begin : g_src
      assign ca    = g_st[k-1].g_op.ra_q[CK-1:0];
      assign cb    = g_st[k-1].g_op.rb_q[CK-1:0];
      assign ci    = g_st[k-1].co_q;
      assign res_d = {sum, g_st[k-1].res_q};
    end

    pipe_addsub_chunk #(.CHUNK(CK)) u_chunk (
      .a(ca), .b(cb), .ci(ci), .s(sum), .co(co)
    );

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        res_q <= '0;
        co_q  <= 1'b0;
      end else if (adv) begin
        res_q <= res_d;
        co_q  <= co;
      end

    // Skew register: the operand bits not yet consumed travel with the carry.
    if (k < STAGES-1) begin : g_op
      localparam int RW = WIDTH - (k+1)*CK;
      logic [RW-1:0] ra_d, rb_d, ra_q, rb_q;
      if (k == 0) begin : g_d
        assign ra_d = a[WIDTH-1:CK];
        assign rb_d = bx[WIDTH-1:CK];
      end else begin : g_d
        assign ra_d = g_st[k-1].g_op.ra_q[RW+CK-1:CK];
        assign rb_d = g_st[k-1].g_op.rb_q[RW+CK-1:CK];
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (adv) begin
          ra_q <= ra_d;
          rb_q <= rb_d;
        end
    end

    if (k == STAGES-1) begin : g_last
      logic cm, cm_q, z_q;
      // Carry into the MSB recovered from the MSB sum bit of the top chunk.
      assign cm = ca[CK-1] ^ cb[CK-1] ^ sum[CK-1];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          cm_q <= 1'b0;
          z_q  <= 1'b0;
        end else if (adv) begin
          cm_q <= cm;
          z_q  <= ~|res_d;
        end
    end
  end

  assign s = g_st[STAGES-1].res_q;
  assign c = g_st[STAGES-1].co_q;
  assign v = g_st[STAGES-1].g_last.cm_q ^ g_st[STAGES-1].co_q;
  assign z = g_st[STAGES-1].g_last.z_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: arithmetic model + ordered scoreboard, directed vectors,
// stall/reset scenarios, and a single-stage WIDTH=16/CHUNK=16 instance.
module tb_pipe_addsub;
  logic        clk, rst_n;
  logic [31:0] a, b, s;
  logic        cin, sub, in_valid, in_ready, c, v, z, out_valid, out_ready;
  logic [15:0] a2, b2, s2;
  logic        cin2, sub2, in_valid2, in_ready2, c2, v2, z2, out_valid2, out_ready2;

  int checks = 0, errors = 0, cyc = 0, stalls = 0;

  typedef struct {
    logic [34:0] r;
    int          cyc;
    int          stl;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [15:0] seen;

  pipe_addsub #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .c(c), .v(v), .z(z),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  pipe_addsub #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .in_valid(in_valid2), .in_ready(in_ready2), .s(s2), .c(c2), .v(v2), .z(z2),
    .out_valid(out_valid2), .out_ready(out_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Result {s,c,v,z} straight from the arithmetic definition.
  function automatic logic [34:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                        input logic icin, input logic isub);
    logic [31:0] bp;
    logic        cp;
    logic [63:0] u;
    longint      ss;
    bp = isub ? ~ib : ib;
    cp = icin ^ isub;
    u  = {32'h0, ia} + {32'h0, bp} + {63'h0, cp};
    ss = longint'($signed(ia)) + longint'($signed(bp)) + longint'(cp);
    model = {u[31:0], u[32], (ss > 64'sd2147483647) || (ss < -64'sd2147483648), u[31:0] == 32'h0};
  endfunction

  // Scoreboard: every cycle, compare against the oldest accepted operation.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      chk("reset_outputs", {in_ready, out_valid, c, v, z, s}, {1'b1, 4'b0, 32'h0});
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_result got s=%h expected no out_valid", s);
        end else begin
          e = q[0];
          chk("result", {s, c, v, z}, e.r);
          if (out_ready) begin
            if (e.stl == stalls) chk("latency", 64'(cyc - e.cyc), 64'd4);
            void'(q.pop_front());
          end else stalls++;
        end
      end
      if (in_valid && in_ready) begin
        e.r = model(a, b, cin, sub); e.cyc = cyc; e.stl = stalls;
        q.push_back(e);
      end
    end
  end

  task automatic op(input logic [31:0] ia, input logic [31:0] ib, input logic icin, input logic isub);
    int   n;
    logic ok;
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk); ok = in_ready; n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready=0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic single(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                        input logic icin, input logic isub, input logic [34:0] exp);
    int n;
    op(ia, ib, icin, isub);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk({nm, "_res"}, {out_valid, s, c, v, z}, {1'b1, exp});
    chk({nm, "_lat"}, 64'(n), 64'd4);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;

    // Pin the model to hand-computed results.
    chk("model_wrap",  model(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0), {32'h00000000, 3'b101});
    chk("model_sub",   model(32'h5, 32'h7, 1'b0, 1'b1),       {32'hFFFFFFFE, 3'b000});
    chk("model_subov", model(32'h80000000, 32'h1, 1'b0, 1'b1), {32'h7FFFFFFF, 3'b110});
    chk("model_addov", model(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0), {32'h80000000, 3'b010});

    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    single("wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h00000000, 3'b101});
    single("sub_neg", 32'h00000005, 32'h00000007, 1'b0, 1'b1, {32'hFFFFFFFE, 3'b000});
    single("sub_ov",  32'h80000000, 32'h00000001, 1'b0, 1'b1, {32'h7FFFFFFF, 3'b110});
    single("add_ov",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h80000000, 3'b010});
    single("cin_add", 32'h0000000F, 32'h000000F0, 1'b1, 1'b0, {32'h00000100, 3'b000});
    single("cin_sub", 32'h00000010, 32'h00000003, 1'b1, 1'b1, {32'h0000000C, 3'b100});
    single("chain",   32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h01000000, 3'b000});
    single("sub_eq",  32'hABCD1234, 32'hABCD1234, 1'b0, 1'b1, {32'h00000000, 3'b101});

    // Eight back-to-back operations: results in 8 consecutive cycles from offset 4.
    seen = '0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          op(32'h11111111 * 32'(i), 32'hF0F0F0F0 ^ 32'(i), 1'(i >> 1), 1'(i));
      end
      begin
        @(negedge clk); seen[0] = out_valid;
        for (int j = 1; j < 16; j++) begin @(negedge clk); seen[j] = out_valid; end
      end
    join
    chk("b2b_pattern", seen, 16'h0FF0);

    // Fill the pipe against a stalled consumer, hold 3 cycles, then release.
    out_ready = 1'b0;
    fork
      begin
        op(32'h1, 32'h2, 1'b0, 1'b0);
        op(32'h3, 32'h4, 1'b0, 1'b0);
        op(32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0);
        op(32'h12345678, 32'h87654321, 1'b0, 1'b1);
        op(32'hDEADBEEF, 32'h00000011, 1'b0, 1'b0);
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 30);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          chk("stall_hold", {in_ready, out_valid, s}, {1'b0, 1'b1, 32'h00000003});
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    repeat (12) @(negedge clk);
    chk("stall_drain", 64'(q.size()), 64'd0);

    // Reset pulse with three operations in flight.
    @(posedge clk); #1;
    op(32'h1000, 32'h1, 1'b0, 1'b0);
    op(32'h2000, 32'h2, 1'b0, 1'b0);
    op(32'h3000, 32'h3, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("pre_reset_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("reset_pulse", {in_ready, out_valid, c, v, z, s}, {1'b1, 4'b0, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    repeat (8) begin @(negedge clk); if (out_valid) n++; end
    chk("no_stale", 64'(n), 64'd0);
    @(posedge clk); #1;
    single("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, {32'h23456789, 3'b000});

    // Single-stage instance: one register, one cycle of latency.
    @(posedge clk); #1;
    a2 = 16'hFFFF; b2 = 16'h0001; cin2 = 1'b0; sub2 = 1'b0; in_valid2 = 1'b1;
    @(negedge clk);
    chk("w16_accept", {in_ready2, out_valid2}, 2'b10);
    @(posedge clk); #1 in_valid2 = 1'b0;
    @(negedge clk);
    chk("w16_res", {out_valid2, s2, c2, v2, z2}, {1'b1, 16'h0000, 3'b101});
    @(negedge clk);
    chk("w16_once", out_valid2, 1'b0);

    repeat (6) @(negedge clk);
    chk("final_drain", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
